// File: rtl/rgb_pwm_fader.sv
// Multi-channel LED PWM driver with a shared OFF/STATIC/BLINK/BREATHE envelope engine.
// Duty registers reload only at the PWM period boundary, so level/mode edits never glitch a period.
module rgb_pwm_fader #(
    parameter int CHANNELS    = 3,
    parameter int PWM_BITS    = 8,
    parameter int DIV_BITS    = 16,
    parameter int BLINK_TICKS = 64,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   mode,
    input  logic [CHANNELS*PWM_BITS-1:0] level,
    input  logic [DIV_BITS-1:0]          div,
    output logic [CHANNELS-1:0]          led,
    output logic                         cycle_done
);

    localparam int BCW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BCW-1:0]      BLINK_LAST = BCW'(BLINK_TICKS - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX    = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] ENV_TOP_M1 = PWM_MAX - PWM_BITS'(1);
    localparam logic [CHANNELS-1:0] LED_OFF    = (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

    localparam logic [1:0] M_OFF     = 2'd0;
    localparam logic [1:0] M_STATIC  = 2'd1;
    localparam logic [1:0] M_BLINK   = 2'd2;
    localparam logic [1:0] M_BREATHE = 2'd3;

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_STATIC    = 3'd1,
        S_BLINK_ON  = 3'd2,
        S_BLINK_OFF = 3'd3,
        S_RAMP_UP   = 3'd4,
        S_RAMP_DOWN = 3'd5
    } state_t;

    logic [DIV_BITS-1:0]               pcnt_r;
    logic [PWM_BITS-1:0]               pcnt_pwm_r;
    logic [PWM_BITS-1:0]               env_r, env_nx_s;
    logic [BCW-1:0]                    bcnt_r, bcnt_nx_s;
    logic [1:0]                        mode_r, mode_nx_s;
    state_t                            state_r, state_nx_s;
    logic [CHANNELS-1:0][PWM_BITS-1:0] duty_r, eff_s;
    logic [CHANNELS-1:0]               lit_s, led_r;
    logic                              tick_s, boundary_s, mode_chg_s, cdone_s, cycle_done_r;

    // Full-width product keeps the floor exact before dropping the low half.
    function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] lvl,
                                                  input logic [PWM_BITS-1:0] env);
        logic [2*PWM_BITS-1:0] prod;
        prod = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, env};
        return prod[2*PWM_BITS-1:PWM_BITS];
    endfunction

    assign tick_s     = (pcnt_r >= div);
    assign boundary_s = (pcnt_pwm_r == PWM_MAX);
    assign mode_chg_s = boundary_s && (mode != mode_r);
    assign led        = led_r;
    assign cycle_done = cycle_done_r;

    // Envelope prescaler and free-running PWM counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_r     <= '0;
            pcnt_pwm_r <= '0;
        end else begin
            pcnt_r     <= tick_s ? '0 : pcnt_r + DIV_BITS'(1);
            pcnt_pwm_r <= pcnt_pwm_r + PWM_BITS'(1);
        end
    end

    // Mode engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_OFF;
            mode_r       <= M_OFF;
            env_r        <= '0;
            bcnt_r       <= '0;
            cycle_done_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            mode_r       <= mode_nx_s;
            env_r        <= env_nx_s;
            bcnt_r       <= bcnt_nx_s;
            cycle_done_r <= cdone_s;
        end
    end

    // Mode engine next state; a mode change at the boundary swallows a coincident tick.
    always_comb begin
        state_nx_s = state_r;
        mode_nx_s  = mode_r;
        env_nx_s   = env_r;
        bcnt_nx_s  = bcnt_r;
        cdone_s    = 1'b0;
        if (mode_chg_s) begin
            mode_nx_s = mode;
            case (mode)
                M_OFF:     state_nx_s = S_OFF;
                M_STATIC:  state_nx_s = S_STATIC;
                M_BLINK: begin
                    state_nx_s = S_BLINK_ON;
                    bcnt_nx_s  = '0;
                end
                M_BREATHE: begin
                    state_nx_s = S_RAMP_UP;
                    env_nx_s   = '0;
                end
                default:   state_nx_s = S_OFF;
            endcase
        end else if (tick_s) begin
            case (state_r)
                S_BLINK_ON, S_BLINK_OFF: begin
                    if (bcnt_r == BLINK_LAST) begin
                        bcnt_nx_s  = '0;
                        state_nx_s = (state_r == S_BLINK_ON) ? S_BLINK_OFF : S_BLINK_ON;
                        cdone_s    = (state_r == S_BLINK_OFF);
                    end else begin
                        bcnt_nx_s = bcnt_r + BCW'(1);
                    end
                end
                S_RAMP_UP: begin
                    env_nx_s = env_r + PWM_BITS'(1);
                    if (env_r == ENV_TOP_M1) begin
                        state_nx_s = S_RAMP_DOWN;
                    end else begin
                        state_nx_s = S_RAMP_UP;
                    end
                end
                S_RAMP_DOWN: begin
                    env_nx_s = env_r - PWM_BITS'(1);
                    if (env_r == PWM_BITS'(1)) begin
                        state_nx_s = S_RAMP_UP;
                        cdone_s    = 1'b1;
                    end else begin
                        state_nx_s = S_RAMP_DOWN;
                    end
                end
                default: state_nx_s = state_r;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Effective duty follows the state being entered so a boundary change lands next period.
    always_comb begin
        eff_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (state_nx_s)
                S_STATIC, S_BLINK_ON:   eff_s[i] = level[i*PWM_BITS +: PWM_BITS];
                S_RAMP_UP, S_RAMP_DOWN: eff_s[i] = scale(level[i*PWM_BITS +: PWM_BITS], env_nx_s);
                default:                eff_s[i] = '0;
            endcase
        end
    end

    // PWM compare.
    always_comb begin
        lit_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            lit_s[i] = (pcnt_pwm_r < duty_r[i]);
        end
    end

    // Duty reload at period boundary and registered LED drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_r <= '0;
            led_r  <= LED_OFF;
        end else begin
            if (boundary_s) begin
                duty_r <= eff_s;
            end
            led_r <= lit_s ^ LED_OFF;
        end
    end

endmodule
